// File: rtl/fifo_wr_ctrl.sv
// Purpose: write-side burst controller feeding a single-clock FIFO with DEPTH-word incrementing bursts.
// Latency: first write SETTLE_CYC+1 edges after empty is first sampled in IDLE; burst_cnt updates 2 edges after the last write.
// Backpressure: fifo_full seen during a write aborts the burst and sets sticky ovf_err; new bursts wait for fifo_empty.
module fifo_wr_ctrl #(
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 256,
    parameter int SETTLE_CYC = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic              fifo_full,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_wr_data,
    output logic              busy,
    output logic [15:0]       burst_cnt,
    output logic              ovf_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(SETTLE_CYC + 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        WRITE,
        DONE
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  settle_cnt;
    logic [IDX_W-1:0]  word_idx;
    logic [DATA_W-1:0] burst_base;

    // First word of a burst is the low bits of the completed-burst count; burst_cnt
    // cannot change during WRITE, so loading it into fifo_wr_data on entry and
    // incrementing per word yields (base + i) mod 2^DATA_W.
    assign burst_base = DATA_W'(burst_cnt);

    // Every state except IDLE counts as busy; derived from the state register only.
    assign busy = (state != IDLE);

    // Burst sequencer: settle qualification, write burst with abort on full, completion count.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state        <= IDLE;
            settle_cnt   <= '0;
            word_idx     <= '0;
            fifo_wr_en   <= 1'b0;
            fifo_wr_data <= '0;
            burst_cnt    <= '0;
            ovf_err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    fifo_wr_en <= 1'b0;
                    if (enable && fifo_empty) begin
                        state      <= SETTLE;
                        settle_cnt <= '0;
                    end
                end

                SETTLE: begin
                    // Any drop of empty or enable restarts qualification from IDLE.
                    // Once SETTLE_CYC consecutive high samples are counted, the next
                    // edge launches word 0 together with fifo_wr_en.
                    if (!fifo_empty || !enable) begin
                        state <= IDLE;
                    end else if (settle_cnt == CNT_W'(SETTLE_CYC)) begin
                        state        <= WRITE;
                        fifo_wr_en   <= 1'b1;
                        fifo_wr_data <= burst_base;
                        word_idx     <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + CNT_W'(1);
                    end
                end

                WRITE: begin
                    // enable is deliberately not looked at here: bursts are atomic.
                    if (fifo_full && fifo_wr_en) begin
                        ovf_err    <= 1'b1;
                        fifo_wr_en <= 1'b0;
                        state      <= DONE;
                    end else if (word_idx == IDX_W'(DEPTH - 1)) begin
                        fifo_wr_en <= 1'b0;
                        state      <= DONE;
                    end else begin
                        word_idx     <= word_idx + IDX_W'(1);
                        fifo_wr_data <= fifo_wr_data + DATA_W'(1);
                    end
                end

                DONE: begin
                    fifo_wr_en <= 1'b0;
                    burst_cnt  <= burst_cnt + 16'd1;
                    state      <= IDLE;
                end

                default: begin
                    fifo_wr_en <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule
